// File: rtl/alu_iter_pkg.sv
// alu_iter_pkg: shared definitions for the iterative ALU.
//   DATA_W      operand/result width (32)
//   CTRL_*      4-bit ALU control codes, shared with the ALU controller
//   state_t     FSM state encoding used by alu_iter
// Related build macro: ALU_ITER_MUL_EN (enables CTRL_MUL in alu_iter).
package alu_iter_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] CTRL_ADD  = 4'b0000;
    localparam logic [3:0] CTRL_SUB  = 4'b0010;
    localparam logic [3:0] CTRL_MUL  = 4'b0011;
    localparam logic [3:0] CTRL_AND  = 4'b0100;
    localparam logic [3:0] CTRL_OR   = 4'b0101;
    localparam logic [3:0] CTRL_SLT  = 4'b1010;
    localparam logic [3:0] CTRL_SLTU = 4'b1011;
    localparam logic [3:0] CTRL_SLLV = 4'b1100;
    localparam logic [3:0] CTRL_SLL  = 4'b1101;
    localparam logic [3:0] CTRL_LUI  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_iter_comb.sv
// alu_iter_comb: purely combinational single-cycle ALU operations.
// Ports:
//   ctrl    in  4       ALU control code
//   src1    in  DATA_W  rs operand
//   src2    in  DATA_W  rt operand / sign-extended immediate
//   result  out DATA_W  result for ADD/SUB/AND/OR/SLT/SLTU/LUI, 0 otherwise
// Shift and multiply codes are iterated by alu_iter and yield 0 here.
module alu_iter_comb
    import alu_iter_pkg::*;
(
    input  logic [3:0]        ctrl,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic [DATA_W-1:0] result
);

    logic slt_bit;
    logic sltu_bit;

    assign slt_bit  = ($signed(src1) < $signed(src2));
    assign sltu_bit = (src1 < src2);

    always_comb begin
        result = '0;
        case (ctrl)
            CTRL_ADD:  result = src1 + src2;
            CTRL_SUB:  result = src1 - src2;
            CTRL_AND:  result = src1 & src2;
            CTRL_OR:   result = src1 | src2;
            CTRL_SLT:  result = {{(DATA_W-1){1'b0}}, slt_bit};
            CTRL_SLTU: result = {{(DATA_W-1){1'b0}}, sltu_bit};
            CTRL_LUI:  result = {src2[15:0], 16'h0000};
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_iter.sv
// alu_iter: iterative multi-cycle ALU with start/done handshake.
// Logic and add/sub finish in one cycle, shifts take one cycle per bit,
// and (with ALU_ITER_MUL_EN defined) MUL runs a 32-step shift-add.
// Build macro: ALU_ITER_MUL_EN -- builds the MUL state and its registers;
// when undefined, code 0011 is treated as an undefined code.
// Ports:
//   clk_i     in  1   clock, rising edge
//   rst_i     in  1   synchronous active-low reset
//   start_i   in  1   request, accepted in IDLE or DONE
//   ctrl_i    in  4   ALU control code
//   src1_i    in  32  rs operand
//   src2_i    in  32  rt operand / immediate
//   shamt_i   in  5   shift amount for SLL
//   busy_o    out 1   SHIFT or MUL in progress
//   done_o    out 1   result_o/zero_o valid this cycle
//   result_o  out 32  result, held until next done_o
//   zero_o    out 1   result_o == 0
//
// state | meaning
// IDLE  | waiting for start_i
// SHIFT | left shift one bit per cycle, count cycles remain
// MUL   | shift-add multiply, one multiplier bit per cycle
// DONE  | result valid; start_i here is accepted back-to-back
module alu_iter
    import alu_iter_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [3:0]        ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [4:0]        shamt_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] comb_res;
    logic [DATA_W-1:0] acc_shl;
    logic [4:0]        shift_k;

`ifdef ALU_ITER_MUL_EN
    // acc_q holds the multiplicand; the multiplier starts in prod_q[31:0]
    // and is consumed from bit 0 as partial sums shift in from the top.
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [5:0]          mcnt_q, mcnt_d;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;

    assign mul_sum  = {1'b0, prod_q[2*DATA_W-1:DATA_W]}
                    + (prod_q[0] ? {1'b0, acc_q} : {(DATA_W+1){1'b0}});
    assign mul_next = {mul_sum, prod_q[DATA_W-1:1]};
`endif

    alu_iter_comb u_comb (
        .ctrl   (ctrl_i),
        .src1   (src1_i),
        .src2   (src2_i),
        .result (comb_res)
    );

    assign acc_shl = {acc_q[DATA_W-2:0], 1'b0};
    assign shift_k = (ctrl_i == CTRL_SLL) ? shamt_i : src1_i[4:0];

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifdef ALU_ITER_MUL_EN
        prod_d   = prod_q;
        mcnt_d   = mcnt_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start_i) begin
                    case (ctrl_i)
                        CTRL_SLL, CTRL_SLLV: begin
                            acc_d = src2_i;
                            cnt_d = shift_k;
                            if (shift_k == 5'd0) begin
                                state_d  = ST_DONE;
                                result_d = src2_i;
                                zero_d   = (src2_i == '0);
                            end else begin
                                state_d = ST_SHIFT;
                            end
                        end
`ifdef ALU_ITER_MUL_EN
                        CTRL_MUL: begin
                            acc_d   = src1_i;
                            prod_d  = {{DATA_W{1'b0}}, src2_i};
                            mcnt_d  = 6'd32;
                            state_d = ST_MUL;
                        end
`endif
                        default: begin
                            // Undefined codes fall through here with comb_res = 0.
                            state_d  = ST_DONE;
                            result_d = comb_res;
                            zero_d   = (comb_res == '0);
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                acc_d = acc_shl;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d  = ST_DONE;
                    result_d = acc_shl;
                    zero_d   = (acc_shl == '0);
                end
            end
            ST_MUL: begin
`ifdef ALU_ITER_MUL_EN
                prod_d = mul_next;
                mcnt_d = mcnt_q - 6'd1;
                if (mcnt_q == 6'd1) begin
                    state_d  = ST_DONE;
                    result_d = mul_next[DATA_W-1:0];
                    zero_d   = (mul_next[DATA_W-1:0] == '0);
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifdef ALU_ITER_MUL_EN
            prod_q   <= '0;
            mcnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifdef ALU_ITER_MUL_EN
            prod_q   <= prod_d;
            mcnt_q   <= mcnt_d;
`endif
        end
    end

    assign busy_o   = (state_q == ST_SHIFT) || (state_q == ST_MUL);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;
    assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: scoreboard bench for alu_iter. The driver pushes the
// reference result and expected done cycle for every accepted request;
// an independent monitor pops and compares on each done_o.
module tb_alu_iter;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [3:0]  ctrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [4:0]  shamt_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        zero_o;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] held = 32'h0;

    alu_iter dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .ctrl_i   (ctrl_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .shamt_i  (shamt_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .zero_o   (zero_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour straight from the operation rules.
    function automatic void ref_op(input logic [3:0] c, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh,
                                   output logic [31:0] r, output int lat);
        lat = 0;
        case (c)
            4'b0000: r = a + b;
            4'b0010: r = a - b;
            4'b0100: r = a & b;
            4'b0101: r = a | b;
            4'b1010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1011: r = (a < b) ? 32'd1 : 32'd0;
            4'b1100: begin r = b << a[4:0]; lat = int'(a[4:0]); end
            4'b1101: begin r = b << sh;     lat = int'(sh);     end
            4'b1111: r = {b[15:0], 16'h0000};
`ifdef ALU_ITER_MUL_EN
            4'b0011: begin r = a * b; lat = 32; end
`endif
            default: r = 32'h0;
        endcase
    endfunction

    // Called at posedge+2 with the DUT able to accept; accept edge is cyc+1.
    task automatic do_op(input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input bit push);
        logic [31:0] r;
        int          lat;
        exp_t        e;
        start_i = 1'b1;
        ctrl_i  = c;
        src1_i  = a;
        src2_i  = b;
        shamt_i = sh;
        if (push) begin
            ref_op(c, a, b, sh, r, lat);
            e.res  = r;
            e.zero = (r == 32'h0);
            e.cyc  = cyc + 1 + lat;
            sb.push_back(e);
        end
        @(posedge clk_i); #2;
        start_i = 1'b0;
        ctrl_i  = 4'($urandom);
        src1_i  = $urandom;
        src2_i  = $urandom;
        shamt_i = 5'($urandom);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 64; i++) begin
            if (!busy_o) return;
            @(posedge clk_i); #2;
        end
        check("ready_timeout", 32'(busy_o), 32'h0);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #2;
        end
    endtask

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i) begin
            held = 32'h0;
        end else if (done_o) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done_o), 32'h0);
            end else begin
                e = sb.pop_front();
                check("result", result_o, e.res);
                check("zero", 32'(zero_o), 32'(e.zero));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                held = e.res;
            end
        end else begin
            check("result_hold", result_o, held);
        end
    end

    initial begin
        int dones;
        logic [3:0] c;
        rst_i   = 1'b0;
        start_i = 1'b0;
        ctrl_i  = 4'h0;
        src1_i  = 32'h0;
        src2_i  = 32'h0;
        shamt_i = 5'h0;
        step(3);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_done", 32'(done_o), 32'h0);
        check("rst_result", result_o, 32'h0);
        check("rst_zero", 32'(zero_o), 32'h0);
        rst_i = 1'b1;
        step(1);

        // Directed cases
        do_op(4'b0000, 32'h7FFFFFFF, 32'h1, 5'd0, 1'b1);
        do_op(4'b0010, 32'd5, 32'd5, 5'd0, 1'b1);
        do_op(4'b1010, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b1);
        do_op(4'b1011, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b1);
        do_op(4'b1111, 32'h0, 32'h00001234, 5'd0, 1'b1);
        do_op(4'b1101, 32'h0, 32'h0000ABCD, 5'd0, 1'b1);
        step(1);

        // SLLV k=4 with an ADD request pulsed while busy
        do_op(4'b1100, 32'd4, 32'h1, 5'd0, 1'b1);
        check("sllv_busy0", 32'(busy_o), 32'h1);
        do_op(4'b0000, 32'd1, 32'd2, 5'd0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            check("sllv_busy", 32'(busy_o), 32'h1);
            step(1);
        end
        check("sllv_idle", 32'(busy_o), 32'h0);
        // Start during the DONE cycle: accepted back-to-back
        do_op(4'b0101, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 1'b1);
        step(1);

        // MUL (or undefined code without the multiplier)
        do_op(4'b0011, 32'h0001_0000, 32'h0001_0001, 5'd0, 1'b1);
        wait_ready();
        do_op(4'b0011, 32'h0000_0007, 32'h0000_0006, 5'd0, 1'b1);
        wait_ready();
        step(2);

        // Reset mid-SLL (k=20): aborts without done
        do_op(4'b1101, 32'h0, 32'h3, 5'd20, 1'b0);
        step(4);
        rst_i = 1'b0;
        step(2);
        check("midrst_busy", 32'(busy_o), 32'h0);
        check("midrst_done", 32'(done_o), 32'h0);
        check("midrst_result", result_o, 32'h0);
        check("midrst_zero", 32'(zero_o), 32'h0);
        rst_i = 1'b1;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            if (done_o) dones++;
            step(1);
        end
        check("midrst_no_done", 32'(dones), 32'h0);

        // Randomized traffic over all 16 codes
        for (int n = 0; n < 200; n++) begin
            wait_ready();
            if ($urandom_range(0, 3) == 0) step($urandom_range(1, 2));
            c = 4'($urandom);
            do_op(c, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                  ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom,
                  5'($urandom), 1'b1);
        end
        wait_ready();
        step(3);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
